// File: rtl/instr_encoder_loader.sv
// Boot/program loader: encodes RV32I instruction requests into 32-bit words and
// writes them sequentially into instruction memory, one word per accepted request.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [20:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FULL
  } loaderState_t;

  loaderState_t state;
  logic [ADDR_W-1:0] ptr;

  // Field packing for each supported format; illegal kinds encode to zero.
  function automatic logic [31:0] encode(
    input logic [2:0]  k,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [4:0]  rdIdx,
    input logic [4:0]  rs1Idx,
    input logic [4:0]  rs2Idx,
    input logic [20:0] im
  );
    logic [31:0] word;
    word = 32'd0;
    case (k)
      3'd0: word = {im[11:0], rs1Idx, f3, rdIdx, 7'b0000011};
      3'd1: word = {im[11:5], rs2Idx, rs1Idx, f3, im[4:0], 7'b0100011};
      3'd2: word = {1'b0, f7b5, 5'b00000, rs2Idx, rs1Idx, f3, rdIdx, 7'b0110011};
      3'd3: word = {im[12], im[10:5], rs2Idx, rs1Idx, f3, im[4:1], im[11], 7'b1100011};
      3'd4: begin
        // Shifts carry the arithmetic/logical select in bit 30 instead of an immediate.
        if (f3 == 3'b101) word = {1'b0, f7b5, 5'b00000, im[4:0], rs1Idx, f3, rdIdx, 7'b0010011};
        else              word = {im[11:0], rs1Idx, f3, rdIdx, 7'b0010011};
      end
      3'd5: word = {im[20], im[10:1], im[11], im[19:12], rdIdx, 7'b1101111};
      default: word = 32'd0;
    endcase
    return word;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= BASE;
      mem_we   <= 1'b0;
      mem_addr <= BASE;
      mem_wd   <= 32'd0;
      count    <= '0;
      err      <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      full     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            ptr      <= BASE;
            count    <= '0;
            err      <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // finish wins over a same-cycle accept; that request is dropped.
          if (finish) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (in_valid && in_ready) begin
            if (kind > 3'd5) begin
              err <= 1'b1;
            end else begin
              mem_we   <= 1'b1;
              mem_addr <= ptr;
              mem_wd   <= encode(kind, funct3, funct7b5, rd, rs1, rs2, imm);
              count    <= count + CNT_W'(1);
              if (ptr == LAST_ADDR) begin
                state    <= FULL;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                full     <= 1'b1;
              end else begin
                ptr <= ptr + ADDR_W'(1);
              end
            end
          end
        end
        FULL: begin
          if (finish) begin
            state <= IDLE;
            full  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          full     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed encodings plus random sessions checked
// against a request-level model of the loader and an arithmetic instruction encoder.
module tb_instr_encoder_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned BASE  = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, finish, in_valid, in_ready;
  logic [2:0]    kind, funct3;
  logic          funct7b5;
  logic [4:0]    rd, rs1, rs2;
  logic [20:0]   imm;
  logic          mem_we, busy, full, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic [AW:0]   count;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .kind(kind), .funct3(funct3),
    .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .count(count),
    .busy(busy), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 = idle, 1 = loading, 2 = memory exhausted
  int          mMode;
  int unsigned mNext, mCount, mAddr;
  bit          mErr, mWe;
  logic [31:0] mWd;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refEncode(input int unsigned k, input int unsigned f3,
                                            input int unsigned f7, input int unsigned rdv,
                                            input int unsigned r1, input int unsigned r2,
                                            input int unsigned im);
    int unsigned w;
    case (k)
      0: w = ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | 32'h03;
      1: w = (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
             | ((im & 32'h1F) << 7) | 32'h23;
      2: w = (f7 << 30) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | 32'h33;
      3: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
             | (r1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
             | (((im >> 11) & 32'h1) << 7) | 32'h63;
      4: begin
        if (f3 == 5) w = (f7 << 30) | ((im & 32'h1F) << 20) | (r1 << 15) | (f3 << 12)
                         | (rdv << 7) | 32'h13;
        else         w = ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | 32'h13;
      end
      5: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
             | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
             | (rdv << 7) | 32'h6F;
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic modelReset();
    mMode = 0; mNext = BASE; mCount = 0; mAddr = BASE; mErr = 0; mWe = 0; mWd = 32'd0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic modelClock();
    mWe = 0;
    if (mMode == 0) begin
      if (start) begin mMode = 1; mNext = BASE; mCount = 0; mErr = 0; end
    end else if (mMode == 1) begin
      if (finish) mMode = 0;
      else if (in_valid) begin
        if (kind > 5) mErr = 1;
        else begin
          mWe = 1; mAddr = mNext; mCount++;
          mWd = refEncode(kind, funct3, funct7b5, rd, rs1, rs2, imm);
          if (mNext == DEPTH - 1) mMode = 2;
          else mNext++;
        end
      end
    end else if (finish) mMode = 0;
  endtask

  task automatic compareAll();
    checkEq("mem_we",   32'(mem_we),   32'(mWe));
    checkEq("mem_addr", 32'(mem_addr), mAddr);
    checkEq("mem_wd",   mem_wd,        mWd);
    checkEq("count",    32'(count),    mCount);
    checkEq("busy",     32'(busy),     32'(mMode == 1));
    checkEq("full",     32'(full),     32'(mMode == 2));
    checkEq("in_ready", 32'(in_ready), 32'(mMode == 1));
    checkEq("err",      32'(err),      32'(mErr));
  endtask

  task automatic step();
    modelClock();
    @(posedge clk);
    #1;
    compareAll();
    start = 1'b0; finish = 1'b0; in_valid = 1'b0;
  endtask

  task automatic req(input int unsigned k, input int unsigned f3, input int unsigned f7,
                     input int unsigned rdv, input int unsigned r1, input int unsigned r2,
                     input int unsigned im);
    in_valid = 1'b1; kind = 3'(k); funct3 = 3'(f3); funct7b5 = 1'(f7);
    rd = 5'(rdv); rs1 = 5'(r1); rs2 = 5'(r2); imm = 21'(im);
    step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    kind = '0; funct3 = '0; funct7b5 = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    reset = 1'b0;

    // Session 1: fill the 4-word memory with lw, sw, add, sub.
    start = 1'b1; step();
    req(0, 2, 0, 5, 2, 0, 8);
    checkEq("lw_word", mem_wd, 32'h00812283);
    req(1, 2, 0, 0, 3, 6, 12);
    checkEq("sw_word", mem_wd, 32'h0061A623);
    checkEq("sw_addr", 32'(mem_addr), 32'd1);
    req(2, 0, 0, 7, 5, 6, 0);
    checkEq("add_word", mem_wd, 32'h006283B3);
    req(2, 0, 1, 7, 5, 6, 0);
    checkEq("sub_word", mem_wd, 32'h406283B3);
    checkEq("full_cnt", 32'(count), 32'd4);
    checkEq("full_flag", 32'(full), 32'd1);
    req(0, 2, 0, 1, 1, 0, 4);
    checkEq("no_fifth_we", 32'(mem_we), 32'd0);
    finish = 1'b1; step();
    checkEq("idle_busy", 32'(busy), 32'd0);

    // Session 2: branch/jump encodings and an illegal kind.
    start = 1'b1; step();
    req(3, 0, 0, 0, 5, 6, 21'h1FFFFC);
    checkEq("beq_word", mem_wd, 32'hFE628EE3);
    req(5, 0, 0, 1, 0, 0, 8);
    checkEq("jal_word", mem_wd, 32'h008000EF);
    req(6, 0, 0, 3, 3, 3, 3);
    checkEq("illegal_err", 32'(err), 32'd1);
    checkEq("illegal_cnt", 32'(count), 32'd2);
    finish = 1'b1; step();
    start = 1'b1; step();
    checkEq("restart_err", 32'(err), 32'd0);
    checkEq("restart_cnt", 32'(count), 32'd0);

    // Reset in the cycle following an accept kills the write immediately.
    req(4, 5, 1, 9, 10, 0, 21'h1F);
    checkEq("pre_reset_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    modelReset();
    compareAll();
    @(posedge clk);
    #1;
    reset = 1'b0;
    compareAll();

    // Random sessions.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 9) == 0);
      finish   = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      kind     = ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      funct3   = 3'($urandom);
      funct7b5 = 1'($urandom);
      rd       = 5'($urandom);
      rs1      = 5'($urandom);
      rs2      = 5'($urandom);
      imm      = 21'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encodes RV32I instruction requests (lw, sw, R-type, beq, I-type ALU, jal) into 32-bit instruction words and writes them sequentially into instruction memory through its write port. It is the producer side of the main decoder: it generates the opcode, funct and immediate field layouts that the decoder consumes. It is used as the boot/program loader and as the stimulus generator for processor benches.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory (depth 2^ADDR_W).
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a load session.
- finish  in  1  pulse; ends a load session.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- kind  in  3  0=lw, 1=sw, 2=R-type, 3=beq, 4=I-ALU, 5=jal, 6/7 illegal.
- funct3  in  3  funct3 field (R, I, S, B, load).
- funct7b5  in  1  instr[30] for R-type; for I-ALU only when funct3=101.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  21  signed immediate; low bits used per format.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wd  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- busy  out  1  high in RUN state.
- full  out  1  high in FULL state.
- err  out  1  sticky illegal-kind flag.

Behaviour:
- Reset (async): state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wd=0, count=0, err=0, in_ready=0.
- States and transitions:
  - IDLE: on start → RUN; ptr=BASE_ADDR, count=0, err=0.
  - RUN: in_ready=1. On finish → IDLE. finish has priority over a same-cycle accept; that request is dropped.
  - FULL: entered after the write to address 2^ADDR_W-1. in_ready=0. finish → IDLE.
- start is ignored outside IDLE.
- Latency: a request accepted at edge N drives mem_we=1, mem_addr=ptr, mem_wd=encoding for exactly the cycle after N. ptr and count increment at that same edge. Back-to-back accepts give one write per cycle.
- Illegal kind: request is consumed, no write occurs, err is set and stays set until the next start. ptr and count are unchanged.
- Wrap: ptr never wraps. An accept that writes the last address moves the state to FULL, so in_ready is 0 in the following cycle.
- Encodings (op in bits [6:0]):
  - lw: imm[11:0], rs1, funct3, rd, 0000011.
  - sw: imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011.
  - R-type: {0, funct7b5, 00000}, rs2, rs1, funct3, rd, 0110011.
  - beq: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011.
  - I-ALU: imm[11:0], rs1, funct3, rd, 0010011. When funct3=101, bit30 is replaced by funct7b5 and bits[31],[29:25] are forced to 0.
  - jal: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
- imm[0] is ignored for beq and jal. Unused imm bits are ignored for every format; no range error is raised.
- Reset asserted mid-session aborts immediately. Any in-flight write is lost (mem_we=0).
- mem_wd holds its last value when mem_we=0.

Test Plan:
- reset, then start, then lw kind=0 rd=5 rs1=2 funct3=010 imm=8 → next cycle mem_we=1, mem_addr=0, mem_wd=0x00812283, count=1.
- Back-to-back requests:
  - sw rs2=6 rs1=3 funct3=010 imm=12 → 0x0061A623 at addr 1.
  - add rd=7 rs1=5 rs2=6 → 0x006283B3 at addr 2.
  - sub (same operands, funct7b5=1) → 0x406283B3 at addr 3.
  - One write per cycle, count=4.
- beq rs1=5 rs2=6 imm=-4 → 0xFE628EE3. jal rd=1 imm=8 → 0x008000EF.
- kind=6 → no mem_we, err=1, count unchanged. Then start → err=0, count=0.
- ADDR_W=2: four valid requests → writes to addrs 0..3, full=1, in_ready=0; a fifth in_valid is not accepted. finish → IDLE, busy=0.
- Assert reset the cycle after an accept → mem_we=0 immediately, state=IDLE, count=0.
